// File: rtl/mo_pkg.sv
// Shared types and constants for the motion-object pixel serializer.
package mo_pkg;

  localparam int PIX_PER_TILE = 8;
  localparam int MAX_TILES    = 8;
  localparam logic [3:0] TRANSPARENT_PEN = 4'hF;

  // Slot counter covers every pixel of the longest strip; the fetch index
  // needs one extra bit so it can run one past the last tile.
  localparam int SLOT_W  = $clog2(PIX_PER_TILE * MAX_TILES);
  localparam int FETCH_W = $clog2(MAX_TILES) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } mo_state_t;

  typedef struct packed {
    logic [7:0] p3;
    logic [7:0] p2;
    logic [7:0] p1;
    logic [7:0] p0;
  } mo_planes_t;

endpackage

// File: rtl/mo_tile_pixel_sel.sv
// Picks the 4-bit pen for one pixel column out of a planar tile.
// Bit 7 of each plane is the leftmost pixel; hflip mirrors the column order.
module mo_tile_pixel_sel
  import mo_pkg::*;
(
  input  logic [31:0] planes,
  input  logic [2:0]  pix,
  input  logic        hflip,
  output logic [3:0]  pen
);

  mo_planes_t tile;
  logic [2:0] bit_idx;

  // Map the slot column to a plane bit and gather one bit from each plane.
  always_comb begin
    tile    = planes;
    bit_idx = hflip ? pix : (3'd7 - pix);
    pen     = {tile.p3[bit_idx], tile.p2[bit_idx], tile.p1[bit_idx], tile.p0[bit_idx]};
  end

endmodule

// File: rtl/mo_pixel_serializer.sv
// Motion-object line-buffer transmit side: accepts one object descriptor,
// double-buffers its planar tiles from the graphics ROM and emits one MOSR
// pixel word per pixel slot with an active-low write strobe.
// Optional build macro MO_UNDERRUN_CNT_EN adds a saturating underrun counter.
module mo_pixel_serializer
  import mo_pkg::*;
(
  input  logic        clk,
  input  logic        reset_b,
  input  logic        pix_en,
  input  logic        obj_valid,
  output logic        obj_ready,
  input  logic [2:0]  obj_color,
  input  logic        obj_hflip,
  input  logic [2:0]  obj_tiles,
  output logic        gfx_req,
  output logic [2:0]  gfx_tile,
  input  logic        gfx_valid,
  input  logic [31:0] gfx_planes,
  output logic [6:0]  mosr,
  output logic        lmpd_b,
  output logic        busy,
  output logic        done
`ifdef MO_UNDERRUN_CNT_EN
  ,
  input  logic        underrun_clr,
  output logic [7:0]  underrun_cnt
`endif
);

  mo_state_t state, state_next;

  logic [2:0]         colour_q;
  logic               hflip_q;
  logic [2:0]         tiles_q;
  logic [SLOT_W-1:0]  slot;
  logic [FETCH_W-1:0] fetch_idx;
  logic [31:0]        tile_buf [2];
  logic [1:0]         buf_valid;

  logic       accept;
  logic       slot_fire;
  logic       last_slot;
  logic       finishing;
  logic       fetch_hit;
  logic       fetch_start;
  logic       cur_buf;
  logic       cur_valid;
  logic [3:0] pen_raw;
  logic [3:0] pen;

  assign accept      = (state == IDLE) && obj_valid;
  assign slot_fire   = (state == RUN) && pix_en;
  assign last_slot   = (slot == {tiles_q, 3'b111});
  assign finishing   = slot_fire && last_slot;
  assign fetch_hit   = (state == RUN) && gfx_req && gfx_valid;
  assign fetch_start = (state == RUN) && !gfx_req && !finishing
                       && (fetch_idx <= {1'b0, tiles_q}) && !buf_valid[fetch_idx[0]];
  assign cur_buf     = slot[3];
  assign cur_valid   = buf_valid[cur_buf];
  assign pen         = cur_valid ? pen_raw : TRANSPARENT_PEN;

  mo_tile_pixel_sel u_pixel_sel (
    .planes (tile_buf[cur_buf]),
    .pix    (slot[2:0]),
    .hflip  (hflip_q),
    .pen    (pen_raw)
  );

  // State register; reset drops any strip in progress without a done pulse.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state: accept in IDLE, run until the last slot, one FINISH cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (obj_valid) state_next = RUN;
      RUN:     if (finishing) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded straight from the state.
  always_comb begin
    obj_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == FINISH);
  end

  // Latch the descriptor on accept and advance the slot counter per pixel slot.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      colour_q <= '0;
      hflip_q  <= 1'b0;
      tiles_q  <= '0;
      slot     <= '0;
    end else if (accept) begin
      colour_q <= obj_color;
      hflip_q  <= obj_hflip;
      tiles_q  <= obj_tiles;
      slot     <= '0;
    end else if (slot_fire) begin
      slot <= slot + 1'b1;
    end
  end

  // ROM fetch sequencing: one outstanding request, issued into a free buffer.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      gfx_req   <= 1'b0;
      gfx_tile  <= '0;
      fetch_idx <= '0;
    end else if (accept) begin
      gfx_req   <= 1'b0;
      fetch_idx <= '0;
    end else if (state != RUN || finishing) begin
      gfx_req <= 1'b0;
    end else if (fetch_hit) begin
      gfx_req   <= 1'b0;
      fetch_idx <= fetch_idx + 1'b1;
    end else if (fetch_start) begin
      gfx_req  <= 1'b1;
      gfx_tile <= fetch_idx[2:0];
    end
  end

  // Tile buffers: freed after their last column, refilled by ROM data (refill wins a tie).
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      buf_valid   <= '0;
      tile_buf[0] <= '0;
      tile_buf[1] <= '0;
    end else if (state != RUN) begin
      buf_valid <= '0;
    end else begin
      if (slot_fire && slot[2:0] == 3'd7) buf_valid[cur_buf] <= 1'b0;
      if (fetch_hit) begin
        buf_valid[fetch_idx[0]] <= 1'b1;
        tile_buf[fetch_idx[0]]  <= gfx_planes;
      end
    end
  end

  // Registered pixel word; the strobe fires only for opaque pens.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      mosr   <= {3'b000, TRANSPARENT_PEN};
      lmpd_b <= 1'b1;
    end else if (slot_fire) begin
      mosr   <= {colour_q, pen};
      lmpd_b <= (pen == TRANSPARENT_PEN);
    end else begin
      lmpd_b <= 1'b1;
    end
  end

`ifdef MO_UNDERRUN_CNT_EN
  // Saturating count of slots that found their tile buffer empty.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)                                       underrun_cnt <= '0;
    else if (underrun_clr)                              underrun_cnt <= '0;
    else if (slot_fire && !cur_valid && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mo_pixel_serializer.sv
// Bench for mo_pixel_serializer: drives descriptors, plays the graphics ROM
// and compares every pixel slot against a tile-buffer reference model.
module tb_mo_pixel_serializer;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        pix_en;
  logic        obj_valid;
  logic        obj_ready;
  logic [2:0]  obj_color;
  logic        obj_hflip;
  logic [2:0]  obj_tiles;
  logic        gfx_req;
  logic [2:0]  gfx_tile;
  logic        gfx_valid;
  logic [31:0] gfx_planes;
  logic [6:0]  mosr;
  logic        lmpd_b;
  logic        busy;
  logic        done;
`ifdef MO_UNDERRUN_CNT_EN
  logic        underrun_clr;
  logic [7:0]  underrun_cnt;
`endif

  int pass_cnt;
  int check_cnt;
  int fail_cnt;

  logic [31:0] rom_data [8];
  logic [31:0] mbuf [2];
  bit          mvalid [2];
  logic [6:0]  exp_mosr;
  int          model_cnt;

  always #5 clk = ~clk;

  mo_pixel_serializer dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .pix_en     (pix_en),
    .obj_valid  (obj_valid),
    .obj_ready  (obj_ready),
    .obj_color  (obj_color),
    .obj_hflip  (obj_hflip),
    .obj_tiles  (obj_tiles),
    .gfx_req    (gfx_req),
    .gfx_tile   (gfx_tile),
    .gfx_valid  (gfx_valid),
    .gfx_planes (gfx_planes),
    .mosr       (mosr),
    .lmpd_b     (lmpd_b),
    .busy       (busy),
    .done       (done)
`ifdef MO_UNDERRUN_CNT_EN
    ,
    .underrun_clr (underrun_clr),
    .underrun_cnt (underrun_cnt)
`endif
  );

  // One comparison: count it, and report tag/observed/expected on a miss.
  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_cnt = check_cnt + 1;
    assert (observed === expected) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic fill_rom_random();
    for (int i = 0; i < 8; i++) rom_data[i] = $urandom;
  endtask

  // Run one strip. The ROM answers each request after 'latency' cycles, except
  // that tile hold_tile is withheld until slot hold_slot is being issued.
  task automatic apply_stimulus(input logic [2:0] colour, input bit hf, input int tiles,
                                input int latency, input int period, input int hold_tile,
                                input int hold_slot, input bit keep_valid, input bit stray,
                                input int reset_slot, input int exp_fetches);
    int nslots;
    int sent, cyc, req_age, next_fetch, deliveries, di;
    int obs_strobes, exp_strobes, b, x, bi;
    bit prev_pix, prev_last, exp_lmpd, pix, deliver;
    logic [3:0]  pen;
    logic [31:0] w;
    nslots = 8 * (tiles + 1);
    sent = 0; cyc = 0; req_age = 0; next_fetch = 0; deliveries = 0;
    obs_strobes = 0; exp_strobes = 0;
    prev_pix = 0; prev_last = 0; exp_lmpd = 1;
    mvalid[0] = 0; mvalid[1] = 0;

    @(negedge clk);
    check_output("idle_ready", obj_ready, 1);
    check_output("idle_busy", busy, 0);
    obj_valid = 1'b1;
    obj_color = colour;
    obj_hflip = hf;
    obj_tiles = 3'(tiles);
    @(negedge clk);
    if (!keep_valid) obj_valid = 1'b0;

    forever begin
      if (prev_pix) begin
        check_output("pix_mosr", mosr, exp_mosr);
        check_output("pix_lmpd", lmpd_b, exp_lmpd);
      end else begin
        check_output("hold_mosr", mosr, exp_mosr);
        check_output("idle_lmpd", lmpd_b, 1);
      end
      if (lmpd_b === 1'b0) obs_strobes++;
      check_output("done", done, prev_last);
      if (prev_last) break;
      check_output("busy_run", busy, 1);
      check_output("ready_run", obj_ready, 0);
      if (gfx_req) begin
        check_output("gfx_tile", gfx_tile, next_fetch);
        check_output("req_range", (next_fetch <= tiles), 1);
      end
      if (cyc > 3000) begin
        check_output("timeout_done", done, 1);
        break;
      end

      if (reset_slot >= 0 && sent == reset_slot) begin
        pix_en = 1'b0; gfx_valid = 1'b0; obj_valid = 1'b0;
        #2 reset_b = 1'b0;
        #1;
        check_output("rst_mosr", mosr, 7'h0F);
        check_output("rst_lmpd", lmpd_b, 1);
        check_output("rst_req", gfx_req, 0);
        check_output("rst_done", done, 0);
        check_output("rst_busy", busy, 0);
        exp_mosr = 7'h0F;
        model_cnt = 0;
        @(negedge clk);
        reset_b = 1'b1;
        #1 check_output("rst_ready", obj_ready, 1);
        repeat (3) begin
          @(negedge clk);
          check_output("rst_no_done", done, 0);
          check_output("rst_idle", busy, 0);
        end
        return;
      end

      deliver = gfx_req && (req_age >= latency) && !(next_fetch == hold_tile && sent < hold_slot);
      pix     = (deliveries > 0) && (sent < nslots) && (cyc % period == 0);

      // Model: the pixel sees buffer contents as they stood before this edge.
      prev_last = 0;
      if (pix) begin
        b  = (sent / 8) % 2;
        x  = sent % 8;
        bi = hf ? x : 7 - x;
        w  = mbuf[b];
        if (mvalid[b]) pen = {w[24+bi], w[16+bi], w[8+bi], w[bi]};
        else begin
          pen = 4'hF;
          if (model_cnt < 255) model_cnt++;
        end
        exp_mosr = {colour, pen};
        exp_lmpd = (pen == 4'hF);
        if (!exp_lmpd) exp_strobes++;
        if (x == 7) mvalid[b] = 0;
        prev_last = (sent == nslots - 1);
        sent++;
      end

      // Fresh ROM data lands after any same-cycle release, so it wins.
      di = next_fetch % 8;
      if (deliver) begin
        mbuf[next_fetch % 2]   = rom_data[di];
        mvalid[next_fetch % 2] = 1;
        next_fetch++;
        deliveries++;
        req_age = 0;
      end else if (gfx_req) begin
        req_age++;
      end

      pix_en     = pix;
      gfx_valid  = deliver || (stray && !gfx_req && ($urandom_range(0, 2) == 0));
      gfx_planes = deliver ? rom_data[di] : $urandom;
      if (keep_valid) begin
        obj_color = 3'($urandom);
        obj_hflip = 1'($urandom);
        obj_tiles = 3'($urandom);
      end
      prev_pix = pix;
      @(negedge clk);
      cyc++;
    end

    obj_valid = 1'b0; pix_en = 1'b0; gfx_valid = 1'b0;
    check_output("strobe_count", obs_strobes, exp_strobes);
    if (exp_fetches >= 0) check_output("fetch_count", deliveries, exp_fetches);
    @(negedge clk);
    check_output("post_busy", busy, 0);
    check_output("post_done", done, 0);
    check_output("post_req", gfx_req, 0);
    check_output("post_lmpd", lmpd_b, 1);
`ifdef MO_UNDERRUN_CNT_EN
    check_output("underrun_cnt", underrun_cnt, model_cnt);
`endif
  endtask

  // Directed sequence: reset, the named scenarios, then a few random strips.
  initial begin
    int t;
    pass_cnt = 0; check_cnt = 0; fail_cnt = 0;
    exp_mosr = 7'h0F; model_cnt = 0;
    reset_b = 1'b0; pix_en = 1'b0; obj_valid = 1'b0; obj_color = '0;
    obj_hflip = 1'b0; obj_tiles = '0; gfx_valid = 1'b0; gfx_planes = '0;
`ifdef MO_UNDERRUN_CNT_EN
    underrun_clr = 1'b0;
`endif
    #12;
    check_output("reset_mosr", mosr, 7'h0F);
    check_output("reset_lmpd", lmpd_b, 1);
    check_output("reset_req", gfx_req, 0);
    check_output("reset_tile", gfx_tile, 0);
    check_output("reset_done", done, 0);
    check_output("reset_busy", busy, 0);
    @(negedge clk);
    reset_b = 1'b1;

    $display("[TB] single tile, no flip");
    rom_data[0] = 32'hFF00_FF00;
    apply_stimulus(3'b101, 0, 0, 0, 1, -1, 0, 0, 0, -1, 1);

    $display("[TB] hflip on and off");
    rom_data[0] = 32'hFFFF_FF80;
    apply_stimulus(3'b011, 1, 0, 0, 1, -1, 0, 0, 0, -1, 1);
    apply_stimulus(3'b011, 0, 0, 0, 1, -1, 0, 0, 0, -1, 1);

    $display("[TB] underrun on tile 1");
    fill_rom_random();
    apply_stimulus(3'b110, 0, 1, 0, 1, 1, 11, 0, 0, -1, 2);

    $display("[TB] max strip, sparse pix_en");
    fill_rom_random();
    apply_stimulus(3'b001, 1, 7, 5, 3, -1, 0, 0, 0, -1, 8);

    $display("[TB] handshake edges");
    fill_rom_random();
    apply_stimulus(3'b010, 0, 3, 0, 1, 1, 15, 1, 1, -1, 3);

    $display("[TB] random strips");
`ifdef MO_UNDERRUN_CNT_EN
    @(negedge clk);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    model_cnt = 0;
`endif
    for (int i = 0; i < 4; i++) begin
      fill_rom_random();
      t = $urandom_range(0, 7);
      apply_stimulus(3'($urandom), 1'($urandom), t, $urandom_range(0, 4),
                     $urandom_range(1, 3), -1, 0, 0, 1'($urandom), -1, t + 1);
    end

    $display("[TB] reset mid-strip");
    fill_rom_random();
    apply_stimulus(3'b111, 0, 3, 1, 1, -1, 0, 0, 0, 20, -1);

    $display("[TB] strip after reset");
    fill_rom_random();
    apply_stimulus(3'b100, 1, 2, 2, 2, -1, 0, 0, 1, -1, 3);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
